uart_packet_assembler: RTL and testbench

Converts the byte stream from the UART receiver into complete header/payload control messages for the test harness register/command decoder. It is the parametrised successor to the fixed 8×8-bit packet handling. Message width, word width, header width and word order are all configurable. It adds an inter-word timeout that discards partial packets, and a one-deep output register with a valid/ready handshake. The input side keeps assembling while the output is stalled.

---
 rtl/uart_pkt_pkg.sv | 32 +++
 rtl/uart_packet_assembler_idle_timeout.sv | 50 +++++
 rtl/uart_packet_assembler.sv | 130 +++++++++++++
 tb/tb_uart_packet_assembler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet assembler: default widths, header
// codes, assembler state encoding and dimension helpers.
package uart_pkt_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_MSG_WIDTH  = 64;

  localparam logic [7:0] MEM_PARAMS   = 8'h01;
  localparam logic [7:0] MOD_PARAMS   = 8'h02;
  localparam logic [7:0] DEMOD_PARAMS = 8'h03;
  localparam logic [7:0] SYS_STATUS   = 8'h04;
  localparam logic [7:0] REPLACE_NUM  = 8'h05;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;

  function automatic int calc_words(input int msg_w, input int data_w);
    return msg_w / data_w;
  endfunction

  // One extra bit so the counter can represent WORDS itself.
  function automatic int count_width(input int words);
    return $clog2(words) + 1;
  endfunction

  function automatic int idle_width(input int timeout_clks);
    return (timeout_clks > 1) ? $clog2(timeout_clks + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_packet_assembler_idle_timeout.sv
// Saturating idle counter: pulses expired on the cycle its count reaches
// TIMEOUT_CLKS while enabled. TIMEOUT_CLKS = 0 disables it entirely.
module idle_timeout_counter
  import uart_pkt_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 810000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = idle_width(TIMEOUT_CLKS);

  generate
    if (TIMEOUT_CLKS == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);
      localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CLKS);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable && (cnt_q != SAT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // The cycle that would bring the count to TIMEOUT_CLKS is the expiry cycle.
      assign expired = enable && !clear && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/uart_packet_assembler.sv
// Assembles UART words into header/payload messages with an inter-word
// timeout and a one-deep valid/ready output register.
module uart_packet_assembler
  import uart_pkt_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int MSG_WIDTH    = DEFAULT_MSG_WIDTH,
  parameter int HEADER_WIDTH = 8,
  parameter bit MSB_FIRST    = 1'b0,
  parameter int TIMEOUT_CLKS = 810000,
  localparam int WORDS       = calc_words(MSG_WIDTH, DATA_WIDTH),
  localparam int CNT_W       = count_width(WORDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic [HEADER_WIDTH-1:0]       out_header,
  output logic [MSG_WIDTH-HEADER_WIDTH-1:0] out_payload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          timeout_err,
  output logic                          overflow_err,
  output logic [CNT_W-1:0]              word_count
);

  asm_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [MSG_WIDTH-1:0] shift_q, shift_d, shifted;
  logic [MSG_WIDTH-1:0] msg_q, msg_d;
  logic                 out_valid_q, out_valid_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 overflow_err_q, overflow_err_d;
  logic                 complete, handshake, idle_en, expired;

  generate
    if (WORDS == 1) begin : g_single
      assign shifted = in_data;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {shift_q[MSG_WIDTH-DATA_WIDTH-1:0], in_data};
    end else begin : g_lsb
      assign shifted = {in_data, shift_q[MSG_WIDTH-1:DATA_WIDTH]};
    end
  endgenerate

  assign handshake = out_valid_q && out_ready;
  assign complete  = in_valid && (count_q == CNT_W'(WORDS - 1));
  assign idle_en   = (state_q == ST_COLLECT) && !in_valid;

  idle_timeout_counter #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_idle (
    .clk    (clk),
    .rst    (rst),
    .clear  (in_valid),
    .enable (idle_en),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (in_valid && !complete) state_d = ST_COLLECT;
      ST_COLLECT: if (complete || expired) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d        = count_q;
    shift_d        = shift_q;
    msg_d          = msg_q;
    out_valid_d    = out_valid_q;
    timeout_err_d  = 1'b0;
    overflow_err_d = 1'b0;
    if (in_valid) begin
      shift_d = shifted;
      count_d = complete ? '0 : count_q + CNT_W'(1);
    end else if (expired) begin
      count_d       = '0;
      timeout_err_d = 1'b1;
    end
    if (handshake) begin
      out_valid_d = 1'b0;
    end
    // A completion can load only into an empty or simultaneously drained register.
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        msg_d       = shifted;
        out_valid_d = 1'b1;
      end else begin
        overflow_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      shift_q        <= '0;
      msg_q          <= '0;
      out_valid_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      shift_q        <= shift_d;
      msg_q          <= msg_d;
      out_valid_q    <= out_valid_d;
      timeout_err_q  <= timeout_err_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  assign out_header   = msg_q[HEADER_WIDTH-1:0];
  assign out_payload  = msg_q[MSG_WIDTH-1:HEADER_WIDTH];
  assign out_valid    = out_valid_q;
  assign timeout_err  = timeout_err_q;
  assign overflow_err = overflow_err_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_uart_packet_assembler.sv
// Bench for uart_packet_assembler: three configurations driven from one
// stimulus stream, checked against directed expectations and a message-level model.
module tb_uart_packet_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic [7:0]  hdr0, hdr1;
  logic [55:0] pl0, pl1;
  logic [3:0]  wc0, wc1;
  logic [3:0]  hdr2, pl2;
  logic [0:0]  wc2;
  logic        ov0, ov1, ov2, te0, te1, te2, oe0, oe1, oe2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_packet_assembler #(.TIMEOUT_CLKS(100)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_header(hdr0), .out_payload(pl0), .out_valid(ov0), .out_ready(out_ready),
    .timeout_err(te0), .overflow_err(oe0), .word_count(wc0));

  uart_packet_assembler #(.MSB_FIRST(1), .TIMEOUT_CLKS(0)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_header(hdr1), .out_payload(pl1), .out_valid(ov1), .out_ready(out_ready),
    .timeout_err(te1), .overflow_err(oe1), .word_count(wc1));

  uart_packet_assembler #(.MSG_WIDTH(8), .HEADER_WIDTH(4), .TIMEOUT_CLKS(3)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_header(hdr2), .out_payload(pl2), .out_valid(ov2), .out_ready(out_ready),
    .timeout_err(te2), .overflow_err(oe2), .word_count(wc2));

  // Reference model: words per message, word order and timeout per instance.
  int          P_W[3]   = '{8, 8, 1};
  bit          P_MSB[3] = '{1'b0, 1'b1, 1'b0};
  int          P_T[3]   = '{100, 0, 3};
  logic [7:0]  m_words[3][8];
  int          m_cnt[3];
  int          m_idle[3];
  bit          m_ov[3];
  bit          m_terr[3];
  bit          m_oerr[3];
  logic [63:0] m_held[3];

  always @(posedge clk) begin
    bit          hs, done;
    logic [63:0] msg;
    for (int k = 0; k < 3; k++) begin
      m_terr[k] = 1'b0;
      m_oerr[k] = 1'b0;
      if (rst) begin
        m_cnt[k]  = 0;
        m_idle[k] = 0;
        m_ov[k]   = 1'b0;
        m_held[k] = '0;
      end else begin
        hs   = m_ov[k] && out_ready;
        done = 1'b0;
        msg  = '0;
        if (in_valid) begin
          m_words[k][m_cnt[k]] = in_data;
          m_cnt[k]++;
          m_idle[k] = 0;
          if (m_cnt[k] == P_W[k]) begin
            done = 1'b1;
            for (int i = 0; i < P_W[k]; i++) begin
              if (P_MSB[k]) msg |= 64'(m_words[k][i]) << (8 * (P_W[k] - 1 - i));
              else          msg |= 64'(m_words[k][i]) << (8 * i);
            end
            m_cnt[k] = 0;
          end
        end else if (m_cnt[k] > 0 && P_T[k] > 0) begin
          m_idle[k]++;
          if (m_idle[k] >= P_T[k]) begin
            m_cnt[k]  = 0;
            m_terr[k] = 1'b1;
          end
        end
        if (hs) m_ov[k] = 1'b0;
        if (done) begin
          if (!m_ov[k] || hs) begin
            m_held[k] = msg;
            m_ov[k]   = 1'b1;
          end else begin
            m_oerr[k] = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [70:0] obs_of(input int k);
    case (k)
      0:       return {ov0, te0, oe0, wc0, pl0, hdr0};
      1:       return {ov1, te1, oe1, wc1, pl1, hdr1};
      default: return {ov2, te2, oe2, 3'b0, wc2, 56'b0, pl2, hdr2};
    endcase
  endfunction

  function automatic logic [70:0] exp_of(input int k);
    return {m_ov[k], m_terr[k], m_oerr[k], 4'(m_cnt[k]), m_held[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_of(k) !== '0) begin
        bad++; $display("FAIL reset_state inst%0d got=%h want=0", k, obs_of(k));
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] pkt[8] = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_word(pkt[i]);
      if (i == 6) begin
        total++;
        if (wc0 !== 4'd7 || ov0 !== 1'b0) begin
          bad++; $display("FAIL basic_partial got wc=%0d ov=%b want wc=7 ov=0", wc0, ov0);
        end
      end
    end
    total++;
    if (ov0 !== 1'b1 || hdr0 !== 8'h02 || pl0 !== 56'h10 || wc0 !== 4'd0) begin
      bad++; $display("FAIL basic_msg got ov=%b hdr=%h pl=%h wc=%0d want 1 02 10 0", ov0, hdr0, pl0, wc0);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_of(k) !== exp_of(k)) begin
        bad++; $display("FAIL basic_model inst%0d got=%h want=%h", k, obs_of(k), exp_of(k));
      end
    end
    tick();
    total++;
    if (ov0 !== 1'b0) begin
      bad++; $display("FAIL basic_drain got ov=%b want 0", ov0);
    end
  endtask

  task automatic test_msb_first();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_word(8'(i));
    total++;
    if (ov1 !== 1'b1 || {pl1, hdr1} !== 64'h0102030405060708 || hdr1 !== 8'h08) begin
      bad++; $display("FAIL msb_msg got ov=%b msg=%h want 1 0102030405060708", ov1, {pl1, hdr1});
    end
    total++;
    if ({pl0, hdr0} !== 64'h0807060504030201) begin
      bad++; $display("FAIL lsb_order got=%h want=0807060504030201", {pl0, hdr0});
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_of(k) !== exp_of(k)) begin
        bad++; $display("FAIL msb_model inst%0d got=%h want=%h", k, obs_of(k), exp_of(k));
      end
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [63:0] a_msg, b_msg;
    int oe_cnt = 0;
    for (int i = 0; i < 2; i++) begin a_msg[32*i +: 32] = $urandom; b_msg[32*i +: 32] = $urandom; end
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(a_msg[8*i +: 8]);
    total++;
    if (ov0 !== 1'b1 || {pl0, hdr0} !== a_msg) begin
      bad++; $display("FAIL ovf_first got ov=%b msg=%h want 1 %h", ov0, {pl0, hdr0}, a_msg);
    end
    for (int i = 0; i < 8; i++) begin
      send_word(b_msg[8*i +: 8]);
      oe_cnt += int'(oe0);
    end
    total++;
    if (oe0 !== 1'b1 || ov0 !== 1'b1 || {pl0, hdr0} !== a_msg) begin
      bad++; $display("FAIL ovf_hold got oe=%b ov=%b msg=%h want 1 1 %h", oe0, ov0, {pl0, hdr0}, a_msg);
    end
    tick();
    oe_cnt += int'(oe0);
    out_ready = 1'b1;
    tick();
    oe_cnt += int'(oe0);
    total++;
    if (ov0 !== 1'b0) begin
      bad++; $display("FAIL ovf_handshake got ov=%b want 0", ov0);
    end
    tick();
    total++;
    if (ov0 !== 1'b0 || oe_cnt != 1) begin
      bad++; $display("FAIL ovf_pulses got ov=%b pulses=%0d want 0 1", ov0, oe_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_of(k) !== exp_of(k)) begin
        bad++; $display("FAIL ovf_model inst%0d got=%h want=%h", k, obs_of(k), exp_of(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a_msg, b_msg;
    for (int i = 0; i < 2; i++) begin a_msg[32*i +: 32] = $urandom; b_msg[32*i +: 32] = $urandom; end
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(a_msg[8*i +: 8]);
    for (int i = 0; i < 7; i++) send_word(b_msg[8*i +: 8]);
    out_ready = 1'b1;
    send_word(b_msg[63:56]);
    total++;
    if (ov0 !== 1'b1 || oe0 !== 1'b0 || {pl0, hdr0} !== b_msg) begin
      bad++; $display("FAIL b2b_load got ov=%b oe=%b msg=%h want 1 0 %h", ov0, oe0, {pl0, hdr0}, b_msg);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_of(k) !== exp_of(k)) begin
        bad++; $display("FAIL b2b_model inst%0d got=%h want=%h", k, obs_of(k), exp_of(k));
      end
    end
    tick();
    total++;
    if (ov0 !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got ov=%b want 0", ov0);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] c_msg;
    int te_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_word(8'($urandom));
    for (int j = 1; j <= 99; j++) begin tick(); te_cnt += int'(te0); end
    total++;
    if (wc0 !== 4'd3 || te_cnt != 0) begin
      bad++; $display("FAIL to_early got wc=%0d pulses=%0d want 3 0", wc0, te_cnt);
    end
    tick();
    total++;
    if (te0 !== 1'b1 || wc0 !== 4'd0) begin
      bad++; $display("FAIL to_fire got te=%b wc=%0d want 1 0", te0, wc0);
    end
    tick();
    total++;
    if (te0 !== 1'b0) begin
      bad++; $display("FAIL to_pulse got te=%b want 0", te0);
    end
    for (int i = 0; i < 2; i++) c_msg[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) send_word(c_msg[8*i +: 8]);
    total++;
    if (ov0 !== 1'b1 || {pl0, hdr0} !== c_msg) begin
      bad++; $display("FAIL to_after got ov=%b msg=%h want 1 %h", ov0, {pl0, hdr0}, c_msg);
    end
    for (int i = 0; i < 2; i++) c_msg[32*i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) send_word(c_msg[8*i +: 8]);
    for (int j = 1; j <= 99; j++) tick();
    send_word(c_msg[31:24]);
    total++;
    if (wc0 !== 4'd4 || te0 !== 1'b0) begin
      bad++; $display("FAIL to_word_wins got wc=%0d te=%b want 4 0", wc0, te0);
    end
    tick();
    total++;
    if (te0 !== 1'b0) begin
      bad++; $display("FAIL to_no_pulse got te=%b want 0", te0);
    end
    for (int i = 4; i < 8; i++) send_word(c_msg[8*i +: 8]);
    total++;
    if (ov0 !== 1'b1 || {pl0, hdr0} !== c_msg) begin
      bad++; $display("FAIL to_late_msg got ov=%b msg=%h want 1 %h", ov0, {pl0, hdr0}, c_msg);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_of(k) !== exp_of(k)) begin
        bad++; $display("FAIL to_model inst%0d got=%h want=%h", k, obs_of(k), exp_of(k));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [63:0] d_msg;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(8'($urandom));
    for (int i = 0; i < 5; i++) send_word(8'($urandom));
    rst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_of(k) !== '0) begin
        bad++; $display("FAIL rst_mid inst%0d got=%h want=0", k, obs_of(k));
      end
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) d_msg[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) send_word(d_msg[8*i +: 8]);
    total++;
    if (ov0 !== 1'b1 || {pl0, hdr0} !== d_msg) begin
      bad++; $display("FAIL rst_after got ov=%b msg=%h want 1 %h", ov0, {pl0, hdr0}, d_msg);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_of(k) !== exp_of(k)) begin
        bad++; $display("FAIL rst_model inst%0d got=%h want=%h", k, obs_of(k), exp_of(k));
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      in_data   = 8'($urandom);
      in_valid  = ((n % 200) < 90) ? ($urandom_range(0, 2) != 0) : ((n % 200) > 196);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_of(k) !== exp_of(k)) begin
          bad++; $display("FAIL rand_model cyc%0d inst%0d got=%h want=%h", n, k, obs_of(k), exp_of(k));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_msb_first();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
